hynoc_packet_injector: RTL and testbench
========================================

# hynoc_packet_injector

Local network-interface stage that converts a packet command (route header word + payload length) and a payload word stream into HyNoC flits. It drives one router ingress port write interface (write strobe, flit data) and throttles itself from that port's fifo full flag and fill level. One instance sits in front of each locally attached ingress port, in the port clock domain.

## Interface
Parameters:
- LOG2_FIFO_DEPTH, 5: log2 depth of the downstream ingress fifo. Must equal the router setting.
- PAYLOAD_WIDTH, 32: payload width.
- FLIT_WIDTH, PAYLOAD_WIDTH+1: flit width. Bit PAYLOAD_WIDTH is the tail marker.
- LEN_WIDTH, 8: width of the payload-length field. A packet carries 0..2^LEN_WIDTH-1 payload flits.
- LEVEL_SLACK, 2: number of free fifo entries held in reserve. Range 1..2^LOG2_FIFO_DEPTH-1.

Ports:
- wclk, in, 1: port clock. Single clock.
- wsrst, in, 1: reset. Synchronous, active-high.
- cmd_valid, in, 1: packet command offered.
- cmd_ready, out, 1: packet command accepted.
- cmd_header, in, PAYLOAD_WIDTH: route header word.
- cmd_length, in, LEN_WIDTH: number of payload flits.
- pld_valid, in, 1: payload word offered.
- pld_ready, out, 1: payload word accepted.
- pld_data, in, PAYLOAD_WIDTH: payload word.
- wen, out, 1: flit write strobe to the ingress fifo. Registered.
- wdata, out, FLIT_WIDTH: flit to the ingress fifo. Registered.
- wfull, in, 1: ingress fifo full.
- wlevel, in, LOG2_FIFO_DEPTH+1: ingress fifo fill level.
- busy, out, 1: high while a packet is in progress (state PAYLOAD).
- pkt_count, out, 16: number of completed packets. Wraps modulo 2^16.

## Operation
- credit_ok = !wfull && (wlevel + wen < 2^LOG2_FIFO_DEPTH - LEVEL_SLACK). The sum is computed at LOG2_FIFO_DEPTH+2 bits, so there is no overflow. Adding wen accounts for the flit currently on the bus.
- The FSM has two states: IDLE and PAYLOAD. Register rem (LEN_WIDTH bits) holds the number of payload flits still to send.
- IDLE:
  - cmd_ready = credit_ok.
  - On cmd handshake: emit the header flit, whose payload bits are cmd_header.
  - If cmd_length == 0: the header flit is also the tail (MSB=1), pkt_count increments, and the FSM stays in IDLE.
  - Otherwise: header MSB=0, rem <= cmd_length, and the FSM goes to PAYLOAD.
- PAYLOAD:
  - pld_ready = credit_ok. cmd_ready = 0.
  - On payload handshake: emit {rem==1, pld_data} and decrement rem.
  - When rem==1: pkt_count increments and the FSM returns to IDLE.
- A flit is emitted only on a handshake cycle. On all other cycles wen=0 and wdata holds its last value.
- pld_ready=0 in IDLE. Payload words offered outside a packet wait and are not consumed.
- Stall: if credit_ok drops mid-packet, no handshake occurs and the FSM, rem and outputs hold. pld_valid may drop at any time; gaps are legal.
- Reset mid-packet: the FSM returns to IDLE immediately and no tail is emitted. wsrst is shared with the ingress fifo reset, so the partial packet is flushed downstream.

## Timing
- Reset values:
  - wen=0, wdata=0, busy=0, pkt_count=0, state=IDLE, rem=0.
  - cmd_ready=0 and pld_ready=0 while wsrst is high.
- Latency: a handshake at edge T puts the flit on wen/wdata during cycle T+1.
- Throughput: one flit per cycle when credit holds. A packet of N payload flits takes N+1 cycles. Back-to-back packets have no bubble: the cmd handshake is accepted in the cycle after the tail handshake.
- cmd_ready and pld_ready are combinational from state, wfull, wlevel and wen only. They never depend on cmd_valid or pld_valid.
- Boundary cases:
  - wlevel = 2^LOG2_FIFO_DEPTH - LEVEL_SLACK - 1 with wen=1: credit_ok=0.
  - wfull=1 overrides any wlevel value.
  - rem wraps never; the length 2^LEN_WIDTH-1 is legal.

## Structure
- Shared package hynoc_pkg holds:
  - TAIL_BIT = PAYLOAD_WIDTH position.
  - The FSM state encoding (IDLE=0, PAYLOAD=1).
  - The credit_ok computation as a function. hynoc_egress-side throttling reuses it.
- No sub-module. The block is a single FSM with a counter and output registers.

## Test plan
- Reset, then cmd {header=0xA5A5_0003, length=3} with payload 0x11, 0x22, 0x33 and wlevel=0 → wen on 4 consecutive cycles with wdata 0x0_A5A50003, 0x0_00000011, 0x0_00000022, 0x1_00000033; pkt_count=1.
- cmd length=0, header=0x0000_0007 → a single flit 0x1_00000007; busy stays 0; pkt_count increments.
- Default parameters, wlevel=29 (32-2-1), with a packet in flight → at most one flit issued, then cmd_ready/pld_ready=0 until wlevel drops to 28 with wen=0.
- wfull=1 for 5 cycles mid-packet with pld_valid=1 → no wen and rem held; the packet resumes and completes with the correct tail.
- Two packets (length 2, then length 1) with both valid streams always high → 5 consecutive wen cycles, tails on flits 3 and 5.
- wsrst asserted after the second payload flit of a length-4 packet → next cycle wen=0, busy=0, pkt_count=0; a new command is accepted right after reset.

Source files
------------

// File: rtl/hynoc_pkg.sv
// Shared HyNoC definitions: tail-bit position, injector FSM encoding and the
// fifo credit check used by both ingress and egress throttling.
package hynoc_pkg;

    localparam int DEF_PAYLOAD_WIDTH = 32;
    localparam int TAIL_BIT          = DEF_PAYLOAD_WIDTH;

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } inj_state_e;

    // The flit already on the write bus is not yet counted in the fifo level,
    // so it is added before comparing against the reserved-slack threshold.
    function automatic logic calc_credit_ok(
        input logic        full,
        input logic [31:0] level,
        input logic        wen_q,
        input int          log2_depth,
        input int          slack
    );
        logic [32:0] sum;
        logic [32:0] limit;
        sum   = {1'b0, level} + {32'b0, wen_q};
        limit = (33'(1) << log2_depth) - 33'(slack);
        return !full && (sum < limit);
    endfunction

endpackage

// File: rtl/hynoc_packet_injector_if.sv
// Packet command, payload stream and ingress-fifo write port of one injector.
// The injector side uses modport slave; the traffic source / fifo side uses master.
interface hynoc_packet_injector_if #(
    parameter int LOG2_FIFO_DEPTH = 5,
    parameter int PAYLOAD_WIDTH   = 32,
    parameter int FLIT_WIDTH      = PAYLOAD_WIDTH + 1,
    parameter int LEN_WIDTH       = 8
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [PAYLOAD_WIDTH-1:0]   cmd_header;
    logic [LEN_WIDTH-1:0]       cmd_length;
    logic                       pld_valid;
    logic                       pld_ready;
    logic [PAYLOAD_WIDTH-1:0]   pld_data;
    logic                       wen;
    logic [FLIT_WIDTH-1:0]      wdata;
    logic                       wfull;
    logic [LOG2_FIFO_DEPTH:0]   wlevel;

    modport slave (
        input  cmd_valid, cmd_header, cmd_length, pld_valid, pld_data, wfull, wlevel,
        output cmd_ready, pld_ready, wen, wdata
    );

    modport master (
        output cmd_valid, cmd_header, cmd_length, pld_valid, pld_data, wfull, wlevel,
        input  cmd_ready, pld_ready, wen, wdata
    );
endinterface

// File: rtl/hynoc_packet_injector.sv
// Turns a packet command plus payload stream into HyNoC flits for one ingress fifo.
// Latency: handshake at edge T -> flit on wen/wdata in cycle T+1; readies drop when fifo credit is exhausted.
module hynoc_packet_injector
    import hynoc_pkg::*;
#(
    parameter int LOG2_FIFO_DEPTH = 5,
    parameter int PAYLOAD_WIDTH   = 32,
    parameter int FLIT_WIDTH      = PAYLOAD_WIDTH + 1,
    parameter int LEN_WIDTH       = 8,
    parameter int LEVEL_SLACK     = 2
) (
    input  logic                    wclk,
    input  logic                    wsrst,
    hynoc_packet_injector_if.slave  bus,
    output logic                    busy,
    output logic [15:0]             pkt_count
);

    inj_state_e              state, state_nxt;
    logic [LEN_WIDTH-1:0]    rem, rem_nxt;
    logic [FLIT_WIDTH-1:0]   wdata_q, flit_nxt;
    logic                    wen_q;
    logic                    emit;
    logic                    done;
    logic                    credit_ok;
    logic                    cmd_rdy;
    logic                    pld_rdy;

    assign credit_ok = calc_credit_ok(bus.wfull, 32'(bus.wlevel), wen_q,
                                      LOG2_FIFO_DEPTH, LEVEL_SLACK);

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        flit_nxt  = '0;
        emit      = 1'b0;
        done      = 1'b0;
        cmd_rdy   = 1'b0;
        pld_rdy   = 1'b0;
        case (state)
            IDLE: begin
                cmd_rdy = credit_ok && !wsrst;
                if (cmd_rdy && bus.cmd_valid) begin
                    emit     = 1'b1;
                    flit_nxt = {(bus.cmd_length == '0), bus.cmd_header};
                    if (bus.cmd_length == '0) begin
                        done = 1'b1;
                    end else begin
                        rem_nxt   = bus.cmd_length;
                        state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                pld_rdy = credit_ok && !wsrst;
                if (pld_rdy && bus.pld_valid) begin
                    emit     = 1'b1;
                    flit_nxt = {(rem == LEN_WIDTH'(1)), bus.pld_data};
                    rem_nxt  = rem - LEN_WIDTH'(1);
                    if (rem == LEN_WIDTH'(1)) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wsrst) begin
            state     <= IDLE;
            rem       <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            pkt_count <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            wen_q <= emit;
            // wdata keeps the last flit between handshakes
            if (emit) wdata_q <= flit_nxt;
            if (done) pkt_count <= pkt_count + 16'd1;
        end
    end

    assign bus.wen       = wen_q;
    assign bus.wdata     = wdata_q;
    assign bus.cmd_ready = cmd_rdy;
    assign bus.pld_ready = pld_rdy;
    assign busy          = (state == PAYLOAD);

endmodule

// File: tb/tb_hynoc_packet_injector.sv
// Randomized and directed bench for hynoc_packet_injector against a flit-sequence reference model.
module tb_hynoc_packet_injector;
    import hynoc_pkg::*;

    logic        wclk;
    logic        wsrst;
    logic        busy;
    logic [15:0] pkt_count;

    hynoc_packet_injector_if #(.LOG2_FIFO_DEPTH(5), .PAYLOAD_WIDTH(32), .FLIT_WIDTH(33), .LEN_WIDTH(8)) bus ();

    hynoc_packet_injector #(
        .LOG2_FIFO_DEPTH(5), .PAYLOAD_WIDTH(32), .FLIT_WIDTH(33), .LEN_WIDTH(8), .LEVEL_SLACK(2)
    ) dut (
        .wclk(wclk), .wsrst(wsrst), .bus(bus), .busy(busy), .pkt_count(pkt_count)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Source queues, expected flit stream (with header markers) and model outputs
    logic [31:0] cmd_hdr_q[$];
    logic [7:0]  cmd_len_q[$];
    logic [31:0] pld_q[$];
    logic [32:0] exp_q[$];
    bit          hdr_q[$];
    logic [32:0] cap_q[$];
    bit          whist[$];
    bit          exp_wen   = 1'b0;
    logic [32:0] exp_wdata = '0;
    logic [15:0] exp_cnt   = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_pkt(input logic [31:0] hdr, input int len, input bit fixed);
        logic [31:0] w;
        cmd_hdr_q.push_back(hdr);
        cmd_len_q.push_back(8'(len));
        exp_q.push_back({(len == 0), hdr});
        hdr_q.push_back(1'b1);
        for (int i = 0; i < len; i++) begin
            w = fixed ? 32'((i + 1) * 32'h11) : $urandom;
            pld_q.push_back(w);
            exp_q.push_back({(i == len - 1), w});
            hdr_q.push_back(1'b0);
        end
    endtask

    // One clock cycle: drive at posedge+1, check readies, then check registered outputs after the edge.
    task automatic step(input bit cv, input bit pv, input bit wf, input int wl, input bit rst);
        bit credit, want_hdr, exp_cr, exp_pr, hs_c, hs_p;
        logic [32:0] flit;
        wsrst          = rst;
        bus.wfull      = wf;
        bus.wlevel     = 6'(wl);
        bus.cmd_valid  = cv && (cmd_hdr_q.size() > 0);
        bus.cmd_header = (cmd_hdr_q.size() > 0) ? cmd_hdr_q[0] : 32'h0;
        bus.cmd_length = (cmd_len_q.size() > 0) ? cmd_len_q[0] : 8'h0;
        bus.pld_valid  = pv && (pld_q.size() > 0);
        bus.pld_data   = (pld_q.size() > 0) ? pld_q[0] : 32'h0;
        #1;
        credit   = !wf && ((wl + int'(exp_wen)) < 32 - 2);
        want_hdr = (hdr_q.size() == 0) || hdr_q[0];
        exp_cr   = !rst && want_hdr && credit;
        exp_pr   = !rst && !want_hdr && credit;
        check_eq("cmd_ready", 64'(bus.cmd_ready), 64'(exp_cr));
        check_eq("pld_ready", 64'(bus.pld_ready), 64'(exp_pr));
        hs_c = bus.cmd_valid && exp_cr;
        hs_p = bus.pld_valid && exp_pr;
        @(posedge wclk);
        #1;
        if (rst) begin
            cmd_hdr_q.delete(); cmd_len_q.delete(); pld_q.delete();
            exp_q.delete(); hdr_q.delete();
            exp_wen = 1'b0; exp_wdata = '0; exp_cnt = '0;
        end else if (hs_c || hs_p) begin
            flit = exp_q.pop_front();
            void'(hdr_q.pop_front());
            if (hs_c) begin
                void'(cmd_hdr_q.pop_front());
                void'(cmd_len_q.pop_front());
            end else begin
                void'(pld_q.pop_front());
            end
            exp_wen   = 1'b1;
            exp_wdata = flit;
            if (flit[TAIL_BIT]) exp_cnt = exp_cnt + 16'd1;
        end else begin
            exp_wen = 1'b0;
        end
        check_eq("wen", 64'(bus.wen), 64'(exp_wen));
        check_eq("wdata", 64'(bus.wdata), 64'(exp_wdata));
        check_eq("busy", 64'(busy), 64'((hdr_q.size() > 0) && !hdr_q[0]));
        check_eq("pkt_count", 64'(pkt_count), 64'(exp_cnt));
        if (bus.wen) cap_q.push_back(bus.wdata);
        whist.push_back(bus.wen);
    endtask

    initial begin
        int  len;
        bit  b2b;
        wsrst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_header = '0; bus.cmd_length = '0;
        bus.pld_valid = 1'b0; bus.pld_data = '0;
        bus.wfull = 1'b0; bus.wlevel = '0;
        @(posedge wclk);
        #1;

        // Reset state
        repeat (2) step(0, 0, 0, 0, 1);

        // Basic 3-payload packet
        push_pkt(32'hA5A5_0003, 3, 1'b1);
        cap_q.delete();
        repeat (6) step(1, 1, 0, 0, 0);
        check_eq("t1_nflits", 64'(cap_q.size()), 64'd4);
        if (cap_q.size() == 4) begin
            check_eq("t1_f0", 64'(cap_q[0]), 64'h0_A5A50003);
            check_eq("t1_f1", 64'(cap_q[1]), 64'h0_00000011);
            check_eq("t1_f2", 64'(cap_q[2]), 64'h0_00000022);
            check_eq("t1_f3", 64'(cap_q[3]), 64'h1_00000033);
        end
        check_eq("t1_cnt", 64'(pkt_count), 64'd1);

        // Zero-length packet: header is also the tail
        push_pkt(32'h0000_0007, 0, 1'b0);
        cap_q.delete();
        repeat (3) step(1, 1, 0, 0, 0);
        check_eq("t2_nflits", 64'(cap_q.size()), 64'd1);
        if (cap_q.size() == 1) check_eq("t2_f0", 64'(cap_q[0]), 64'h1_00000007);
        check_eq("t2_cnt", 64'(pkt_count), 64'd2);

        // Credit boundary: level 29 admits one flit, then the bus flit closes the window
        push_pkt($urandom, 4, 1'b0);
        cap_q.delete();
        step(1, 1, 0, 29, 0);
        step(1, 1, 0, 29, 0);
        repeat (3) step(1, 1, 0, 30, 0);
        check_eq("t3_nflits", 64'(cap_q.size()), 64'd1);
        repeat (3) step(1, 1, 0, 28, 0);
        repeat (6) step(1, 1, 0, 0, 0);
        check_eq("t3_cnt", 64'(pkt_count), 64'd3);

        // wfull stall mid-packet
        push_pkt($urandom, 3, 1'b0);
        repeat (2) step(1, 1, 0, 0, 0);
        cap_q.delete();
        repeat (5) step(1, 1, 1, 3, 0);
        check_eq("t4_stall", 64'(cap_q.size()), 64'd0);
        repeat (4) step(1, 1, 0, 0, 0);
        check_eq("t4_nflits", 64'(cap_q.size()), 64'd2);
        if (cap_q.size() == 2) check_eq("t4_tail", 64'(cap_q[1][TAIL_BIT]), 64'd1);
        check_eq("t4_cnt", 64'(pkt_count), 64'd4);

        // Back-to-back packets with no bubble
        push_pkt($urandom, 2, 1'b0);
        push_pkt($urandom, 1, 1'b0);
        cap_q.delete();
        whist.delete();
        repeat (7) step(1, 1, 0, 0, 0);
        b2b = 1'b1;
        for (int i = 0; i < 5; i++) b2b = b2b && (whist.size() > i) && whist[i];
        check_eq("t5_run5", 64'(b2b), 64'd1);
        check_eq("t5_nflits", 64'(cap_q.size()), 64'd5);
        if (cap_q.size() == 5) begin
            check_eq("t5_tail3", 64'({cap_q[1][TAIL_BIT], cap_q[2][TAIL_BIT]}), 64'b01);
            check_eq("t5_tail5", 64'({cap_q[3][TAIL_BIT], cap_q[4][TAIL_BIT]}), 64'b01);
        end

        // Reset mid-packet, then immediate new command
        push_pkt($urandom, 4, 1'b0);
        repeat (3) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        check_eq("t6_cnt", 64'(pkt_count), 64'd0);
        check_eq("t6_busy", 64'(busy), 64'd0);
        push_pkt($urandom, 1, 1'b0);
        step(1, 1, 0, 0, 0);
        check_eq("t6_accept", 64'(bus.wen), 64'd1);
        repeat (3) step(1, 1, 0, 0, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (cmd_hdr_q.size() < 2) begin
                len = ($urandom_range(0, 39) == 0) ? 255 : int'($urandom_range(0, 6));
                push_pkt($urandom, len, 1'b0);
            end
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) == 0,
                 ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 31)),
                 $urandom_range(0, 499) == 0);
        end
        for (int c = 0; c < 600 && exp_q.size() > 0; c++) step(1, 1, 0, 0, 0);
        check_eq("drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
